// File: rtl/serial_frame_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_pkg
// Shared definitions for the serial frame receiver:
//   state_e   - receiver FSM state encoding (3-bit)
//   LINE_IDLE - level of the serial line when no frame is in progress
// ---------------------------------------------------------------------------
package serial_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_shift_in.sv
// ---------------------------------------------------------------------------
// serial_shift_in
// DATA_W-bit LSB-first shift register with a running XOR of every bit that
// has been shifted in since the last clear.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   clr      - clear data and running parity (has priority over shift_en)
//   shift_en - shift bit_in in at the top; after DATA_W shifts the first bit
//              sits in data[0]
//   bit_in   - serial bit to shift in
//   data     - current register contents
//   par      - XOR of all bits shifted in since the last clear
// ---------------------------------------------------------------------------
module serial_shift_in #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data,
  output logic              par
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] feed;
  logic              par_q, par_d;

  // Each bit takes its upper neighbour; the new bit enters at the top so the
  // first bit received ends up in bit 0 once the word is complete.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_feed
      if (gi == DATA_W - 1) begin : g_top
        assign feed[gi] = bit_in;
      end else begin : g_mid
        assign feed[gi] = data_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (clr) begin
      data_d = '0;
      par_d  = 1'b0;
    end else if (shift_en) begin
      data_d = feed;
      par_d  = par_q ^ bit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data = data_q;
  assign par  = par_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver
// Samples one bit per clock on D and assembles frames of the form
//   start(0), DATA_W data bits LSB first, [even parity], stop(1).
// Ports:
//   CLK       - clock, all sampling on the rising edge
//   RST_n     - asynchronous active-low reset
//   D         - serial line, idle high
//   DOUT      - last correctly received word (changes only with VALID)
//   VALID     - one-cycle pulse, DOUT updated in this cycle
//   FRAME_ERR - one-cycle pulse, stop bit sampled low
//   PAR_ERR   - one-cycle pulse, parity mismatch (PARITY_EN=1 only)
//   BUSY      - high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              D,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  output logic              FRAME_ERR,
  output logic              PAR_ERR,
  output logic              BUSY
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              par_err_q, par_err_d;
  logic              busy_q, busy_d;

  logic              sh_clr;
  logic              sh_en;
  logic [DATA_W-1:0] sh_data;
  logic              sh_par;

  // The shifter is cleared by the start bit itself, so a frame starting right
  // after the previous stop bit begins from a clean register.
  assign sh_clr = (state_q == ST_IDLE) && (D != LINE_IDLE);
  assign sh_en  = (state_q == ST_DATA);

  serial_shift_in #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (CLK),
    .rst_n    (RST_n),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .bit_in   (D),
    .data     (sh_data),
    .par      (sh_par)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    par_bad_d   = par_bad_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (D != LINE_IDLE) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          par_bad_d = 1'b0;
        end
      end

      ST_DATA: begin
        // Counter tops out at DATA_W, which fits in CNT_W bits.
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
      end

      ST_PARITY: begin
        // Even parity: data XOR parity bit must be zero.
        par_bad_d = sh_par ^ D;
        state_d   = ST_STOP;
      end

      ST_STOP: begin
        if (D == LINE_IDLE) begin
          state_d = ST_IDLE;
          if (par_bad_q) begin
            par_err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            dout_d  = sh_data;
          end
        end else begin
          state_d     = ST_WAIT_IDLE;
          frame_err_d = 1'b1;
          par_err_d   = par_bad_q;
        end
      end

      ST_WAIT_IDLE: begin
        // A low line here is a break or a broken frame, never a start bit.
        if (D == LINE_IDLE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      par_bad_q   <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_bad_q   <= par_bad_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      busy_q      <= busy_d;
    end
  end

  assign DOUT      = dout_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign PAR_ERR   = par_err_q;
  assign BUSY      = busy_q;

endmodule
